// File: rtl/tfhe_stream_slice.sv
// Streaming toy-LWE brightness slice: encrypt pixel and brightness, add/subtract
// the ciphertexts, decrypt, and deliver the result over a valid/ready stream.
module tfhe_stream_slice #(
    parameter int                P_BITS     = 8,
    parameter int                Q_BITS     = 12,
    parameter logic [Q_BITS-1:0] SECRET_KEY = 12'd1337,
    parameter int                ERR        = 1,
    parameter logic [15:0]       SEED1      = 16'hACE1,
    parameter logic [15:0]       SEED2      = 16'h1D2B
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [P_BITS-1:0] in_pixel,
    input  logic [P_BITS-1:0] in_bright,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [P_BITS-1:0] out_pixel,
    output logic [31:0]       beat_count
);

    localparam int                SHIFT      = Q_BITS - P_BITS;
    localparam int                DELTA      = 1 << SHIFT;
    localparam logic [Q_BITS-1:0] ERR_Q      = Q_BITS'(ERR);
    localparam logic [Q_BITS-1:0] HALF_DELTA = Q_BITS'(DELTA / 2);

    logic              advance;
    logic              accept;
    logic [P_BITS-1:0] msg   [2];
    logic [Q_BITS-1:0] ct_a  [2];
    logic [Q_BITS-1:0] ct_b  [2];

    logic              s1_valid_reg;
    logic              s1_sub_reg;
    logic              s2_valid_reg;
    logic [Q_BITS-1:0] s2_a_reg;
    logic [Q_BITS-1:0] s2_b_reg;
    logic              out_valid_reg;
    logic [P_BITS-1:0] out_pixel_reg;
    logic [31:0]       beat_count_reg;

    logic [Q_BITS-1:0] sum_a_next;
    logic [Q_BITS-1:0] sum_b_next;
    logic [Q_BITS-1:0] phase;
    logic [Q_BITS-1:0] rounded;
    logic [P_BITS-1:0] dec_pixel;

    // The whole pipeline moves as one; a stalled output freezes every stage.
    assign advance  = !out_valid_reg || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    assign msg[0] = in_pixel;
    assign msg[1] = in_bright;

    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
        localparam logic [15:0] SEED = (gi == 0) ? SEED1 : SEED2;

        logic [15:0]       lfsr_reg;
        logic [Q_BITS-1:0] s1_a_reg;
        logic [Q_BITS-1:0] s1_b_reg;
        logic [Q_BITS-1:0] key;
        logic [Q_BITS-1:0] a_times_s;
        logic [Q_BITS-1:0] enc_b;
        logic              feedback;

        assign key       = lfsr_reg[Q_BITS-1:0];
        assign a_times_s = key * SECRET_KEY;
        assign enc_b     = a_times_s + {msg[gi], {SHIFT{1'b0}}} + ERR_Q;
        // x^16 + x^14 + x^13 + x^11 + 1
        assign feedback  = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lfsr_reg <= SEED;
                s1_a_reg <= '0;
                s1_b_reg <= '0;
            end else begin
                // The key is consumed by this beat before the register steps.
                if (accept) begin
                    lfsr_reg <= {lfsr_reg[14:0], feedback};
                end
                if (advance) begin
                    s1_a_reg <= key;
                    s1_b_reg <= enc_b;
                end
            end
        end

        assign ct_a[gi] = s1_a_reg;
        assign ct_b[gi] = s1_b_reg;
    end

    assign sum_a_next = s1_sub_reg ? (ct_a[0] - ct_a[1]) : (ct_a[0] + ct_a[1]);
    assign sum_b_next = s1_sub_reg ? (ct_b[0] - ct_b[1]) : (ct_b[0] + ct_b[1]);

    // Round to the nearest multiple of DELTA to strip the accumulated error.
    assign phase     = s2_b_reg - s2_a_reg * SECRET_KEY;
    assign rounded   = phase + HALF_DELTA;
    assign dec_pixel = P_BITS'(rounded >> SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_sub_reg    <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s2_a_reg      <= '0;
            s2_b_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_pixel_reg <= '0;
        end else if (advance) begin
            s1_valid_reg  <= in_valid;
            s1_sub_reg    <= in_sub;
            s2_valid_reg  <= s1_valid_reg;
            s2_a_reg      <= sum_a_next;
            s2_b_reg      <= sum_b_next;
            out_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                out_pixel_reg <= dec_pixel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count_reg <= '0;
        end else if (out_valid_reg && out_ready) begin
            beat_count_reg <= beat_count_reg + 32'd1;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_pixel  = out_pixel_reg;
    assign beat_count = beat_count_reg;

    // Decryption is only exact if the doubled error stays below DELTA/2.
    config_ok: assert property (@(posedge clk) disable iff (!rst_n)
        (ERR >= 0) && (ERR < DELTA / 4) && (Q_BITS > P_BITS + 2) && (Q_BITS <= 16));

endmodule

// File: tb/tb_tfhe_stream_slice.sv
// Bench for tfhe_stream_slice: expected pixels come from plain mod-256 arithmetic,
// expected keys from a polynomial-stepped LFSR model.
`timescale 1ns/1ps
module tb_tfhe_stream_slice;

    localparam logic [15:0] SEED1 = 16'hACE1;
    localparam logic [15:0] SEED2 = 16'h1D2B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b1;
    logic [7:0]  in_pixel = '0, in_bright = '0;
    logic        in_ready, out_valid;
    logic [7:0]  out_pixel;
    logic [31:0] beat_count;

    logic        w_in_valid = 1'b0, w_in_sub = 1'b0, w_out_ready = 1'b1;
    logic [7:0]  w_in_pixel = '0, w_in_bright = '0;
    logic        w_in_ready, w_out_valid;
    logic [7:0]  w_out_pixel;
    logic [31:0] w_beat_count;

    tfhe_stream_slice dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .in_bright(in_bright), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .beat_count(beat_count)
    );

    tfhe_stream_slice #(.P_BITS(8), .Q_BITS(14), .SECRET_KEY(14'd1337), .ERR(3)) dut_wide (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_pixel(w_in_pixel), .in_bright(w_in_bright), .in_sub(w_in_sub),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pixel(w_out_pixel),
        .beat_count(w_beat_count)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          got_t[$];
    logic [15:0] m_lfsr1 = SEED1;
    logic [15:0] m_lfsr2 = SEED2;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back(out_pixel);
            got_t.push_back(cyc);
        end
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        int taps[4] = '{16, 14, 13, 11};
        logic fb;
        fb = 1'b0;
        foreach (taps[t]) fb = fb ^ v[taps[t] - 1];
        return {v[14:0], fb};
    endfunction

    function automatic int power_on_b(input int m);
        int a;
        a = int'(SEED1) % 4096;
        return (a * 1337 + m * 16 + 1) % 4096;
    endfunction

    // Present one beat on the 12-bit instance and hold it until accepted.
    task automatic send(input logic [7:0] p, input logic [7:0] b, input logic s);
        logic [7:0] e;
        logic done;
        done = 1'b0;
        in_valid = 1'b1; in_pixel = p; in_bright = b; in_sub = s;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e = s ? (p - b) : (p + b);
                exp_q.push_back(e);
                m_lfsr1 = lfsr_step(m_lfsr1);
                m_lfsr2 = lfsr_step(m_lfsr2);
                acc_cyc = cyc;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL send_accept: got in_ready=0 for 100 cycles, want acceptance");
        end
    endtask

    task automatic clear_queues();
        exp_q.delete(); got_q.delete(); got_t.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        vectors += 6;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        if (out_pixel !== 8'd0) begin miscompares++; $display("FAIL reset_out_pixel: got %0d want 0", out_pixel); end
        if (beat_count !== 32'd0) begin miscompares++; $display("FAIL reset_beat_count: got %0d want 0", beat_count); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        if (dut.g_operand[0].lfsr_reg !== SEED1) begin miscompares++; $display("FAIL reset_lfsr1: got %h want %h", dut.g_operand[0].lfsr_reg, SEED1); end
        if (dut.g_operand[1].lfsr_reg !== SEED2) begin miscompares++; $display("FAIL reset_lfsr2: got %h want %h", dut.g_operand[1].lfsr_reg, SEED2); end
        rst_n = 1'b1;
        m_lfsr1 = SEED1; m_lfsr2 = SEED2;
        clear_queues();
        @(posedge clk); #1;
    endtask

    task automatic test_first_beat();
        int want_b;
        clear_queues();
        out_ready = 1'b1;
        send(8'd100, 8'd20, 1'b0);
        want_b = power_on_b(100);
        vectors += 2;
        if (dut.g_operand[0].s1_a_reg !== SEED1[11:0]) begin miscompares++; $display("FAIL first_key: got %h want %h", dut.g_operand[0].s1_a_reg, SEED1[11:0]); end
        if (dut.g_operand[0].s1_b_reg !== 12'(want_b)) begin miscompares++; $display("FAIL first_ct_b: got %0d want %0d", dut.g_operand[0].s1_b_reg, want_b); end
        for (int k = 0; k < 20 && got_q.size() < 1; k++) @(negedge clk);
        @(posedge clk); #1;
        vectors++;
        if (got_q.size() < 1) begin
            miscompares++; $display("FAIL first_result: got no result want 120");
        end else begin
            $display("first beat: pixel=100 bright=20 add -> %0d after %0d cycles", got_q[0], got_t[0] - acc_cyc);
            vectors += 2;
            if (got_q[0] !== 8'd120) begin miscompares++; $display("FAIL first_pixel: got %0d want 120", got_q[0]); end
            if (got_t[0] - acc_cyc != 3) begin miscompares++; $display("FAIL first_latency: got %0d want 3", got_t[0] - acc_cyc); end
        end
        vectors++;
        if (beat_count !== 32'd1) begin miscompares++; $display("FAIL first_beat_count: got %0d want 1", beat_count); end
    endtask

    task automatic test_wrap();
        logic [7:0] pix[4]  = '{8'd250, 8'd30, 8'd0, 8'd255};
        logic [7:0] brt[4]  = '{8'd10, 8'd50, 8'd0, 8'd255};
        logic       sub[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] want[4] = '{8'd4, 8'd236, 8'd0, 8'd0};
        clear_queues();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(pix[i], brt[i], sub[i]);
        for (int k = 0; k < 30 && got_q.size() < 4; k++) @(negedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= got_q.size()) begin
                miscompares++; $display("FAIL wrap_%0d: got nothing want %0d", i, want[i]);
            end else begin
                $display("wrap beat %0d: %0d %s %0d -> %0d", i, pix[i], sub[i] ? "-" : "+", brt[i], got_q[i]);
                if (got_q[i] !== want[i]) begin miscompares++; $display("FAIL wrap_%0d: got %0d want %0d", i, got_q[i], want[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_lfsr1 = SEED1; m_lfsr2 = SEED2;
        clear_queues();
        for (int i = 0; i < 256; i++) send(8'(i), 8'd7, i[0]);
        for (int k = 0; k < 300 && got_q.size() < 256; k++) @(negedge clk);
        @(posedge clk); #1;
        vectors++;
        if (got_q.size() != 256) begin
            miscompares++; $display("FAIL b2b_count: got %0d results want 256", got_q.size());
        end else begin
            for (int i = 0; i < 256; i++) begin
                vectors++;
                $display("stream beat %0d: got %0d want %0d", i, got_q[i], exp_q[i]);
                if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_pixel_%0d: got %0d want %0d", i, got_q[i], exp_q[i]); end
            end
            vectors++;
            if (got_t[255] - got_t[0] != 255) begin miscompares++; $display("FAIL b2b_gapless: got span %0d want 255", got_t[255] - got_t[0]); end
        end
        vectors++;
        if (beat_count !== 32'd256) begin miscompares++; $display("FAIL b2b_beat_count: got %0d want 256", beat_count); end
    endtask

    task automatic test_backpressure();
        clear_queues();
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
            end
            begin
                logic [31:0] bc;
                for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
                @(posedge clk); #1;
                out_ready = 1'b0;
                bc = beat_count;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    vectors += 5;
                    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
                    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid: got %0b want 1", out_valid); end
                    if (out_pixel !== exp_q[1]) begin miscompares++; $display("FAIL bp_hold_pixel: got %0d want %0d", out_pixel, exp_q[1]); end
                    if (beat_count !== bc) begin miscompares++; $display("FAIL bp_beat_count: got %0d want %0d", beat_count, bc); end
                    if (dut.g_operand[0].lfsr_reg !== m_lfsr1 || dut.g_operand[1].lfsr_reg !== m_lfsr2) begin
                        miscompares++;
                        $display("FAIL bp_lfsr_frozen: got %h/%h want %h/%h", dut.g_operand[0].lfsr_reg, dut.g_operand[1].lfsr_reg, m_lfsr1, m_lfsr2);
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 40 && got_q.size() < 6; k++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (got_q.size() != 6) begin
            miscompares++; $display("FAIL bp_count: got %0d results want 6", got_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                $display("backpressure beat %0d: got %0d want %0d", i, got_q[i], exp_q[i]);
                if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_pixel_%0d: got %0d want %0d", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_queues();
        out_ready = 1'b1;
        send(8'd11, 8'd22, 1'b0);
        send(8'd33, 8'd44, 1'b1);
        send(8'd55, 8'd66, 1'b0);
        rst_n = 1'b0;
        #1;
        vectors += 3;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %0b want 0", out_valid); end
        if (dut.g_operand[0].lfsr_reg !== SEED1) begin miscompares++; $display("FAIL midrst_lfsr1: got %h want %h", dut.g_operand[0].lfsr_reg, SEED1); end
        if (dut.g_operand[1].lfsr_reg !== SEED2) begin miscompares++; $display("FAIL midrst_lfsr2: got %h want %h", dut.g_operand[1].lfsr_reg, SEED2); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_lfsr1 = SEED1; m_lfsr2 = SEED2;
        clear_queues();
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (got_q.size() != 0) begin miscompares++; $display("FAIL midrst_discard: got %0d results want 0", got_q.size()); end
        send(8'd100, 8'd20, 1'b0);
        vectors += 2;
        if (dut.g_operand[0].s1_a_reg !== SEED1[11:0]) begin miscompares++; $display("FAIL midrst_key: got %h want %h", dut.g_operand[0].s1_a_reg, SEED1[11:0]); end
        if (dut.g_operand[0].s1_b_reg !== 12'(power_on_b(100))) begin miscompares++; $display("FAIL midrst_ct_b: got %0d want %0d", dut.g_operand[0].s1_b_reg, power_on_b(100)); end
        for (int k = 0; k < 20 && got_q.size() < 1; k++) @(negedge clk);
        @(posedge clk); #1;
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== 8'd120) begin
            miscompares++; $display("FAIL midrst_result: got %0d results (first %0d) want one result 120", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'd0);
        end else begin
            $display("post-reset beat: pixel=100 bright=20 add -> %0d", got_q[0]);
        end
    endtask

    task automatic test_param_sweep();
        logic [7:0]  wq[$];
        logic [15:0] l1;
        logic [7:0]  e;
        logic        took;
        int          acc;
        int          del;
        l1 = SEED1; acc = 0; del = 0;
        in_valid = 1'b0; w_in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 20000 && del < 1000; k++) begin
            if (!w_in_valid && acc < 1000 && $urandom_range(0, 3) != 0) begin
                w_in_valid = 1'b1;
                w_in_pixel = 8'($urandom); w_in_bright = 8'($urandom); w_in_sub = 1'($urandom);
            end
            w_out_ready = ($urandom_range(0, 3) != 0);
            took = 1'b0;
            @(negedge clk);
            if (w_in_valid && w_in_ready) begin
                e = w_in_sub ? (w_in_pixel - w_in_bright) : (w_in_pixel + w_in_bright);
                wq.push_back(e);
                l1 = lfsr_step(l1);
                acc++;
                took = 1'b1;
            end
            if (w_out_valid && w_out_ready) begin
                vectors++;
                if (wq.size() == 0) begin
                    miscompares++; $display("FAIL sweep_extra_%0d: got %0d want no beat", del, w_out_pixel);
                end else begin
                    $display("sweep beat %0d: got %0d want %0d", del, w_out_pixel, wq[0]);
                    if (w_out_pixel !== wq[0]) begin miscompares++; $display("FAIL sweep_pixel_%0d: got %0d want %0d", del, w_out_pixel, wq[0]); end
                    void'(wq.pop_front());
                end
                del++;
            end
            @(posedge clk); #1;
            if (took) w_in_valid = 1'b0;
        end
        w_out_ready = 1'b1;
        vectors += 3;
        if (del != 1000) begin miscompares++; $display("FAIL sweep_delivered: got %0d want 1000", del); end
        if (w_beat_count !== 32'd1000) begin miscompares++; $display("FAIL sweep_beat_count: got %0d want 1000", w_beat_count); end
        if (dut_wide.g_operand[0].lfsr_reg !== l1) begin miscompares++; $display("FAIL sweep_lfsr1: got %h want %h", dut_wide.g_operand[0].lfsr_reg, l1); end
    endtask

    initial begin
        test_reset();
        test_first_beat();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no completion within 2ms want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
